// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: display fetches always own the RAM, CPU commands
// wait in an in-order FIFO and issue in display-idle cycles.
module vram_arbiter #(
    parameter int AddrBits  = 16,
    parameter int FifoDepth = 4,
    parameter int StallBits = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         dispReq,
    input  logic [AddrBits-1:0]          dispAddr,
    output logic [7:0]                   dispData,
    input  logic                         cpuReq,
    input  logic                         cpuWe,
    input  logic [AddrBits-1:0]          cpuAddr,
    input  logic [7:0]                   cpuWrData,
    output logic                         cpuReady,
    output logic                         cpuRdValid,
    output logic [7:0]                   cpuRdData,
    output logic [$clog2(FifoDepth):0]   fifoCount,
    input  logic                         clearStats,
    output logic [StallBits-1:0]         stallCycles,
    output logic [AddrBits-1:0]          ramAddr,
    output logic                         ramWe,
    output logic [7:0]                   ramDataOut,
    input  logic [7:0]                   ramDataIn
);
    localparam int PtrBits = $clog2(FifoDepth);
    localparam int CntBits = PtrBits + 1;

    logic [AddrBits-1:0]  addr_q [FifoDepth];
    logic [AddrBits-1:0]  addr_d [FifoDepth];
    logic [7:0]           data_q [FifoDepth];
    logic [7:0]           data_d [FifoDepth];
    logic                 we_q   [FifoDepth];
    logic                 we_d   [FifoDepth];

    logic [PtrBits-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PtrBits-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CntBits-1:0]   count_q, count_d;
    logic                 rd_pend_q, rd_pend_d;
    logic                 rd_valid_q, rd_valid_d;
    logic [7:0]           rd_data_q, rd_data_d;
    logic [StallBits-1:0] stall_q, stall_d;

    logic push;
    logic cpu_grant;

    assign cpuReady    = (count_q != CntBits'(FifoDepth));
    assign fifoCount   = count_q;
    assign cpuRdValid  = rd_valid_q;
    assign cpuRdData   = rd_data_q;
    assign stallCycles = stall_q;
    assign dispData    = ramDataIn;

    always_comb begin
        push      = cpuReq && cpuReady;
        cpu_grant = !dispReq && (count_q != '0);

        addr_d   = addr_q;
        data_d   = data_q;
        we_d     = we_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (push) begin
            addr_d[wr_ptr_q] = cpuAddr;
            data_d[wr_ptr_q] = cpuWrData;
            we_d[wr_ptr_q]   = cpuWe;
            wr_ptr_d         = wr_ptr_q + PtrBits'(1);
        end
        if (cpu_grant) begin
            rd_ptr_d = rd_ptr_q + PtrBits'(1);
        end
        case ({push, cpu_grant})
            2'b10:   count_d = count_q + CntBits'(1);
            2'b01:   count_d = count_q - CntBits'(1);
            default: count_d = count_q;
        endcase

        // RAM data for a read issued last cycle is on ramDataIn now, whoever owns the RAM today
        rd_pend_d  = cpu_grant && !we_q[rd_ptr_q];
        rd_valid_d = rd_pend_q;
        rd_data_d  = rd_pend_q ? ramDataIn : rd_data_q;

        stall_d = stall_q;
        if (clearStats) begin
            stall_d = '0;
        end else if (dispReq && (count_q != '0) && (stall_q != '1)) begin
            stall_d = stall_q + StallBits'(1);
        end

        ramAddr    = '0;
        ramWe      = 1'b0;
        ramDataOut = '0;
        if (dispReq) begin
            ramAddr = dispAddr;
        end else if (cpu_grant) begin
            ramAddr    = addr_q[rd_ptr_q];
            ramWe      = we_q[rd_ptr_q];
            ramDataOut = data_q[rd_ptr_q];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            rd_pend_q  <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
            stall_q    <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            rd_pend_q  <= rd_pend_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
            stall_q    <= stall_d;
        end
    end

    // Entry storage needs no reset: only slots counted by count_q are ever granted
    always_ff @(posedge clk) begin
        addr_q <= addr_d;
        data_q <= data_d;
        we_q   <= we_d;
    end
endmodule
